fwd_tag_pipe: RTL and testbench
===============================

// Module: fwd_tag_pipe
// PURPOSE
//  Carries destination-register tags and write-control bits from ID through EX and MEM.
//  These tags feed the forwarding unit: ex_rd, mem_rd, mem_rt, *_regwrite, mem_memwrite, mem_wb_brlink.
//  Detects load-use hazards and freezes IF/ID via a stall FSM for STALL_CYCLES cycles, injecting EX bubbles.
//  Squashes the ID instruction on a taken-branch flush.
// PARAMETERS
//  STALL_CYCLES  1   cycles stall is held per load-use hazard (legal 1..7)
//  ZERO_REG      31  architectural zero register (XZR); tag never forwarded
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  id_valid       in   1   ID holds a real instruction
//  id_rn, id_rm   in   5   ID source registers (hazard compare)
//  id_uses_rn     in   1   instruction reads Rn
//  id_uses_rm     in   1   instruction reads Rm
//  id_rd          in   5   ID destination register
//  id_rt          in   5   ID store-data register
//  id_regwrite    in   1   ID writes a register
//  id_memread     in   1   ID is a load
//  id_memwrite    in   1   ID is a store
//  id_brlink      in   1   ID is BL (writes X30)
//  flush          in   1   taken branch: squash ID instruction
//  stall          out  1   hold PC and IF/ID this cycle
//  ex_rd          out  5   EX destination tag
//  ex_regwrite    out  1   EX write-control bit
//  ex_memread     out  1   EX is a load
//  mem_rd         out  5   MEM destination tag
//  mem_rt         out  5   MEM store-data tag
//  mem_regwrite   out  1   MEM write-control bit
//  mem_memwrite   out  1   MEM is a store
//  mem_wb_brlink  out  1   MEM/WB BL pending
// BEHAVIOUR
//  - Bubble: rd=rt=ZERO_REG, all control bits 0.
//  - Reset: EX and MEM are bubbles, state=RUN, cnt=0, stall=0.
//  - MEM always advances: MEM <= EX each cycle. id_brlink propagates to mem_wb_brlink.
//  - EX <= ID only if id_valid & !flush & !stall; otherwise EX <= bubble.
//  - hazard = id_valid & ex_memread & ex_regwrite & ex_rd!=ZERO_REG
//      & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
//  - FSM states RUN, HOLD; 3-bit down-counter cnt.
//  - RUN: stall = hazard & !flush. Same-cycle (Mealy) assertion.
//      If stall and STALL_CYCLES>1: go to HOLD, cnt=STALL_CYCLES-1.
//  - HOLD: stall=1 unless flush; cnt decrements each cycle; cnt==1 -> RUN next cycle.
//  - Total stall = exactly STALL_CYCLES cycles per hazard. A new hazard after return to RUN starts a new stall.
//  - flush priority: flush beats hazard and HOLD. stall=0, EX <= bubble, state -> RUN, cnt=0.
//  - Reset during HOLD aborts the stall; next cycle is RUN with all bubbles.
//  - Tags are exact 5-bit compares; ZERO_REG destinations never trigger a hazard.
//  - No combinational path from outputs back to inputs; stall depends only on inputs and state.
// CONFIGURATION
//  FWD_PIPE_STATS_EN defined:
//   - adds outputs stall_cycles[15:0] and flush_count[15:0].
//   - Both are saturating at 16'hFFFF and cleared by reset.
//   - stall_cycles +1 per cycle with stall=1; flush_count +1 per cycle with flush=1.
//  FWD_PIPE_STATS_EN undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  - Reset: hold reset 2 cycles mid-traffic -> stall=0, ex_rd=mem_rd=31, all controls 0 next cycle.
//  - Pass-through: ADD X3 (id_rd=3, regwrite) -> ex_rd=3 at +1, mem_rd=3 with mem_regwrite=1 at +2, stall never set.
//  - Load-use, STALL_CYCLES=1: LDUR X5 then ADD using Rn=5.
//      -> stall=1 for 1 cycle; EX bubble (ex_rd=31); ADD enters EX on the next cycle.
//  - Load-use, STALL_CYCLES=3: same sequence -> stall held exactly 3 cycles, 3 EX bubbles.
//      Loading into X31 -> no stall.
//  - Flush mid-HOLD (STALL_CYCLES=3): flush on 2nd stall cycle -> stall=0 that cycle, state RUN, EX bubble.
//  - BL then consumer: id_brlink=1, id_rd=30 -> mem_wb_brlink=1 two cycles later.
//      With FWD_PIPE_STATS_EN: after a 3-cycle stall plus one flush, stall_cycles=3 and flush_count=1.

Source files
------------

// File: rtl/fwd_tag_pipe_if.sv
// Handshake bundle between the ID stage and the tag pipe: ID-side decode
// fields plus flush in, stall and the EX/MEM forwarding tags out.
interface fwd_tag_pipe_if;
   logic       id_valid;
   logic [4:0] id_rn;
   logic [4:0] id_rm;
   logic       id_uses_rn;
   logic       id_uses_rm;
   logic [4:0] id_rd;
   logic [4:0] id_rt;
   logic       id_regwrite;
   logic       id_memread;
   logic       id_memwrite;
   logic       id_brlink;
   logic       flush;
   logic       stall;
   logic [4:0] ex_rd;
   logic       ex_regwrite;
   logic       ex_memread;
   logic [4:0] mem_rd;
   logic [4:0] mem_rt;
   logic       mem_regwrite;
   logic       mem_memwrite;
   logic       mem_wb_brlink;

   modport master (
      output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_rt,
             id_regwrite, id_memread, id_memwrite, id_brlink, flush,
      input  stall, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_rt,
             mem_regwrite, mem_memwrite, mem_wb_brlink
   );

   modport slave (
      input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_rt,
             id_regwrite, id_memread, id_memwrite, id_brlink, flush,
      output stall, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_rt,
             mem_regwrite, mem_memwrite, mem_wb_brlink
   );
endinterface

// File: rtl/fwd_tag_pipe.sv
// ID->EX->MEM destination-tag pipe with load-use stall FSM and flush squash.
// Optional FWD_PIPE_STATS_EN adds saturating stall/flush event counters.
module fwd_tag_pipe #(
   parameter int unsigned STALL_CYCLES = 1,
   parameter int unsigned ZERO_REG     = 31
) (
   input  logic          clk,
   input  logic          reset,
   fwd_tag_pipe_if.slave bus
`ifdef FWD_PIPE_STATS_EN
   ,
   output logic [15:0]   stall_cycles,
   output logic [15:0]   flush_count
`endif
);

   localparam logic [4:0] ZR       = 5'(ZERO_REG);
   localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

   typedef enum logic {
      RUN,
      HOLD
   } state_t;

   state_t     state;
   logic [2:0] cnt;

   logic [4:0] ex_rd_q, ex_rt_q;
   logic       ex_rw_q, ex_mr_q, ex_mw_q, ex_bl_q;
   logic [4:0] mem_rd_q, mem_rt_q;
   logic       mem_rw_q, mem_mw_q, mem_bl_q;

   logic hazard;
   logic stall_c;
   logic ex_load;

   assign hazard = bus.id_valid & ex_mr_q & ex_rw_q & (ex_rd_q != ZR) &
                   ((bus.id_uses_rn & (bus.id_rn == ex_rd_q)) |
                    (bus.id_uses_rm & (bus.id_rm == ex_rd_q)));

   // Mealy stall: flush always wins, HOLD keeps the freeze regardless of hazard
   assign stall_c = bus.flush ? 1'b0 : ((state == HOLD) ? 1'b1 : hazard);
   assign ex_load = bus.id_valid & ~bus.flush & ~stall_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         cnt      <= '0;
         ex_rd_q  <= ZR;
         ex_rt_q  <= ZR;
         ex_rw_q  <= 1'b0;
         ex_mr_q  <= 1'b0;
         ex_mw_q  <= 1'b0;
         ex_bl_q  <= 1'b0;
         mem_rd_q <= ZR;
         mem_rt_q <= ZR;
         mem_rw_q <= 1'b0;
         mem_mw_q <= 1'b0;
         mem_bl_q <= 1'b0;
      end else begin
         mem_rd_q <= ex_rd_q;
         mem_rt_q <= ex_rt_q;
         mem_rw_q <= ex_rw_q;
         mem_mw_q <= ex_mw_q;
         mem_bl_q <= ex_bl_q;

         if (ex_load) begin
            ex_rd_q <= bus.id_rd;
            ex_rt_q <= bus.id_rt;
            ex_rw_q <= bus.id_regwrite;
            ex_mr_q <= bus.id_memread;
            ex_mw_q <= bus.id_memwrite;
            ex_bl_q <= bus.id_brlink;
         end else begin
            ex_rd_q <= ZR;
            ex_rt_q <= ZR;
            ex_rw_q <= 1'b0;
            ex_mr_q <= 1'b0;
            ex_mw_q <= 1'b0;
            ex_bl_q <= 1'b0;
         end

         if (bus.flush) begin
            state <= RUN;
            cnt   <= '0;
         end else begin
            case (state)
               RUN: begin
                  // the RUN cycle itself is the first stall cycle
                  if (stall_c && (STALL_CYCLES > 1)) begin
                     state <= HOLD;
                     cnt   <= CNT_INIT;
                  end
               end
               HOLD: begin
                  cnt <= cnt - 3'd1;
                  if (cnt == 3'd1) state <= RUN;
               end
               default: begin
                  state <= RUN;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.stall         = stall_c;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.ex_regwrite   = ex_rw_q;
   assign bus.ex_memread    = ex_mr_q;
   assign bus.mem_rd        = mem_rd_q;
   assign bus.mem_rt        = mem_rt_q;
   assign bus.mem_regwrite  = mem_rw_q;
   assign bus.mem_memwrite  = mem_mw_q;
   assign bus.mem_wb_brlink = mem_bl_q;

`ifdef FWD_PIPE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_c && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
         if (bus.flush && (flush_count != '1)) flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_tag_pipe.sv
// Directed bench for fwd_tag_pipe: vector table on a STALL_CYCLES=1 instance,
// hand sequences for multi-cycle stall, flush-in-HOLD and reset on a =3 instance.
module tb_fwd_tag_pipe;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       v, urn, urm, rw, mr, mw, bl, fl;
   logic [4:0] rn, rm, rd, rt;

   fwd_tag_pipe_if b1 ();
   fwd_tag_pipe_if b3 ();

   assign b1.id_valid = v;    assign b3.id_valid = v;
   assign b1.id_rn = rn;      assign b3.id_rn = rn;
   assign b1.id_rm = rm;      assign b3.id_rm = rm;
   assign b1.id_uses_rn = urn; assign b3.id_uses_rn = urn;
   assign b1.id_uses_rm = urm; assign b3.id_uses_rm = urm;
   assign b1.id_rd = rd;      assign b3.id_rd = rd;
   assign b1.id_rt = rt;      assign b3.id_rt = rt;
   assign b1.id_regwrite = rw; assign b3.id_regwrite = rw;
   assign b1.id_memread = mr; assign b3.id_memread = mr;
   assign b1.id_memwrite = mw; assign b3.id_memwrite = mw;
   assign b1.id_brlink = bl;  assign b3.id_brlink = bl;
   assign b1.flush = fl;      assign b3.flush = fl;

`ifdef FWD_PIPE_STATS_EN
   logic [15:0] sc1, fc1, sc3, fc3;
   fwd_tag_pipe #(.STALL_CYCLES(1), .ZERO_REG(31)) u1 (
      .clk(clk), .reset(reset), .bus(b1), .stall_cycles(sc1), .flush_count(fc1));
   fwd_tag_pipe #(.STALL_CYCLES(3), .ZERO_REG(31)) u3 (
      .clk(clk), .reset(reset), .bus(b3), .stall_cycles(sc3), .flush_count(fc3));
`else
   fwd_tag_pipe #(.STALL_CYCLES(1), .ZERO_REG(31)) u1 (.clk(clk), .reset(reset), .bus(b1));
   fwd_tag_pipe #(.STALL_CYCLES(3), .ZERO_REG(31)) u3 (.clk(clk), .reset(reset), .bus(b3));
`endif

   // {stall, ex_rd, ex_rw, ex_mr, mem_rd, mem_rt, mem_rw, mem_mw, mem_bl}
   logic [20:0] o1, o3;
   assign o1 = {b1.stall, b1.ex_rd, b1.ex_regwrite, b1.ex_memread, b1.mem_rd,
                b1.mem_rt, b1.mem_regwrite, b1.mem_memwrite, b1.mem_wb_brlink};
   assign o3 = {b3.stall, b3.ex_rd, b3.ex_regwrite, b3.ex_memread, b3.mem_rd,
                b3.mem_rt, b3.mem_regwrite, b3.mem_memwrite, b3.mem_wb_brlink};

   localparam logic [20:0] IDLE_OUT = {1'b0, 5'd31, 2'b00, 5'd31, 5'd31, 3'b000};

   typedef struct {
      logic v; logic [4:0] rn, rm; logic urn, urm; logic [4:0] rd, rt;
      logic rw, mr, mw, bl, fl;
      logic st; logic [4:0] erd; logic erw, emr; logic [4:0] mrd, mrt;
      logic mrw, mmw, mbl;
   } vec_t;

   vec_t tbl [24];
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic iv, input logic [4:0] irn, input logic [4:0] irm,
                         input logic iurn, input logic iurm, input logic [4:0] ird,
                         input logic [4:0] irt, input logic irw, input logic imr,
                         input logic imw, input logic ibl, input logic ifl);
      v = iv; rn = irn; rm = irm; urn = iurn; urm = iurm; rd = ird; rt = irt;
      rw = irw; mr = imr; mw = imw; bl = ibl; fl = ifl;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic ldur_x5();
      set_in(1, 2, 0, 1, 0, 5, 0, 1, 1, 0, 0, 0);
   endtask
   task automatic add_x6(input logic ifl);
      set_in(1, 5, 9, 1, 1, 6, 0, 1, 0, 0, 0, ifl);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      // inputs | stall, ex_rd, ex_rw, ex_mr, mem_rd, mem_rt, mem_rw, mem_mw, mem_bl
      tbl[0]  = '{1,1,2,1,1,3,7,1,0,0,0,0,   0,31,0,0,31,31,0,0,0};
      tbl[1]  = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,3,1,0,31,31,0,0,0};
      tbl[2]  = '{1,2,0,1,0,5,0,1,1,0,0,0,   0,31,0,0,3,7,1,0,0};
      tbl[3]  = '{1,5,9,1,1,6,0,1,0,0,0,0,   1,5,1,1,31,31,0,0,0};
      tbl[4]  = '{1,5,9,1,1,6,0,1,0,0,0,0,   0,31,0,0,5,0,1,0,0};
      tbl[5]  = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,6,1,0,31,31,0,0,0};
      tbl[6]  = '{1,1,0,1,0,31,0,1,1,0,0,0,  0,31,0,0,6,0,1,0,0};
      tbl[7]  = '{1,31,31,1,1,8,0,1,0,0,0,0, 0,31,1,1,31,31,0,0,0};
      tbl[8]  = '{1,8,0,1,0,31,4,0,0,1,0,0,  0,8,1,0,31,0,1,0,0};
      tbl[9]  = '{1,0,0,0,0,30,0,1,0,0,1,0,  0,31,0,0,8,0,1,0,0};
      tbl[10] = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,30,1,0,31,4,0,1,0};
      tbl[11] = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,31,0,0,30,0,1,0,1};
      tbl[12] = '{1,0,0,0,0,9,0,1,0,0,0,1,   0,31,0,0,31,31,0,0,0};
      tbl[13] = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,31,0,0,31,31,0,0,0};
      tbl[14] = '{1,1,0,1,0,7,0,1,1,0,0,0,   0,31,0,0,31,31,0,0,0};
      tbl[15] = '{1,0,7,0,1,2,0,1,0,0,0,1,   0,7,1,1,31,31,0,0,0};
      tbl[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,31,0,0,7,0,1,0,0};
      tbl[17] = '{1,1,0,1,0,7,0,1,1,0,0,0,   0,31,0,0,31,31,0,0,0};
      tbl[18] = '{1,7,3,0,1,2,0,1,0,0,0,0,   0,7,1,1,31,31,0,0,0};
      tbl[19] = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,2,1,0,7,0,1,0,0};
      tbl[20] = '{1,1,0,1,0,7,0,1,1,0,0,0,   0,31,0,0,2,0,1,0,0};
      tbl[21] = '{1,0,7,0,1,2,0,1,0,0,0,0,   1,7,1,1,31,31,0,0,0};
      tbl[22] = '{1,0,7,0,1,2,0,1,0,0,0,0,   0,31,0,0,7,0,1,0,0};
      tbl[23] = '{0,0,0,0,0,0,0,0,0,0,0,0,   0,2,1,0,31,31,0,0,0};

      idle();
      do_reset();
      chk("reset_state_s1", 32'(o1), 32'(IDLE_OUT));
      chk("reset_state_s3", 32'(o3), 32'(IDLE_OUT));
`ifdef FWD_PIPE_STATS_EN
      chk("reset_stall_cycles", 32'(sc3), 32'd0);
      chk("reset_flush_count", 32'(fc3), 32'd0);
`endif

      for (int i = 0; i < 24; i++) begin
         set_in(tbl[i].v, tbl[i].rn, tbl[i].rm, tbl[i].urn, tbl[i].urm, tbl[i].rd,
                tbl[i].rt, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].bl, tbl[i].fl);
         #1;
         chk($sformatf("vec%0d", i), 32'(o1),
             32'({tbl[i].st, tbl[i].erd, tbl[i].erw, tbl[i].emr, tbl[i].mrd,
                  tbl[i].mrt, tbl[i].mrw, tbl[i].mmw, tbl[i].mbl}));
         step();
      end

      // three-cycle load-use stall with three EX bubbles
      idle();
      do_reset();
      ldur_x5();
      #1;
      chk("s3_load_nostall", 32'(b3.stall), 32'd0);
      step();
      add_x6(0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("s3_stall_c%0d", i), 32'(b3.stall), (i < 3) ? 32'd1 : 32'd0);
         chk($sformatf("s3_exrd_c%0d", i), 32'(b3.ex_rd), (i == 0) ? 32'd5 : 32'd31);
         step();
      end
      idle();
      #1;
      chk("s3_add_in_ex", 32'({b3.ex_rd, b3.ex_regwrite}), 32'({5'd6, 1'b1}));
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      idle();
      #1;
`ifdef FWD_PIPE_STATS_EN
      chk("stats_stall_cycles", 32'(sc3), 32'd3);
      chk("stats_flush_count", 32'(fc3), 32'd1);
`endif

      // flush on the second stall cycle returns to RUN
      do_reset();
      ldur_x5();
      step();
      add_x6(0);
      #1;
      chk("fh_stall_first", 32'(b3.stall), 32'd1);
      step();
      add_x6(1);
      #1;
      chk("fh_flush_stall", 32'(b3.stall), 32'd0);
      step();
      add_x6(0);
      #1;
      chk("fh_run_nostall", 32'(b3.stall), 32'd0);
      chk("fh_ex_bubble", 32'({b3.ex_rd, b3.ex_regwrite, b3.ex_memread}), 32'({5'd31, 2'b00}));
      step();
      idle();
      #1;
      chk("fh_add_in_ex", 32'(b3.ex_rd), 32'd6);

      // reset while in HOLD, consumer still presented
      do_reset();
      ldur_x5();
      step();
      add_x6(0);
      step();
      #1;
      chk("rh_in_hold", 32'(b3.stall), 32'd1);
      do_reset();
      chk("rh_after_reset", 32'(o3), 32'(IDLE_OUT));
      step();
      #1;
      chk("rh_add_in_ex", 32'(b3.ex_rd), 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
